// File: rtl/stereo_gain_ramp_pkg.sv
// audio_pkg: shared widths, gain constants, saturation limits and FSM states
package audio_pkg;
  localparam int BITSIZE = 24;
  localparam int GAIN_W = 16;
  localparam int GAIN_FRAC = 14;
  localparam int STEP = 256;
  localparam int UNITY_GAIN = 1 << GAIN_FRAC;
  localparam int PROD_W = BITSIZE + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (BITSIZE - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (BITSIZE - 1)));
  typedef enum logic [2:0] {IDLE, CAP, MUL_L, MUL_R, OUT} state_t;
endpackage

// File: rtl/stereo_gain_ramp_if.sv
// stereo_gain_ramp_if: sample, gain and frame-clock bundle between i2s_rx/tx and the gain stage
interface stereo_gain_ramp_if;
  import audio_pkg::*;
  logic lrclk;
  logic [BITSIZE-1:0] in_left;
  logic [BITSIZE-1:0] in_right;
  logic [GAIN_W-1:0] target_gain;
  logic mute;
  logic [BITSIZE-1:0] out_left;
  logic [BITSIZE-1:0] out_right;
  logic out_valid;
  logic [GAIN_W-1:0] gain_now;
  modport master(output lrclk, in_left, in_right, target_gain, mute,
                 input out_left, out_right, out_valid, gain_now);
  modport slave(input lrclk, in_left, in_right, target_gain, mute,
                output out_left, out_right, out_valid, gain_now);
endinterface

// File: rtl/stereo_gain_ramp_sat_scale.sv
// sat_scale: signed sample times unsigned Q2.14 gain, floor shift, saturate to sample width
module sat_scale
  import audio_pkg::*;
(
  input  logic signed [BITSIZE-1:0] sample,
  input  logic        [GAIN_W-1:0]  gain,
  output logic signed [BITSIZE-1:0] result
);
  logic signed [PROD_W-1:0] p;
  logic signed [PROD_W-1:0] r;
  always_comb begin
    p = PROD_W'(sample) * $signed(PROD_W'({1'b0, gain}));
    r = p >>> GAIN_FRAC;
    result = r > SAT_MAX ? BITSIZE'(SAT_MAX) : r < SAT_MIN ? BITSIZE'(SAT_MIN) : BITSIZE'(r);
  end
endmodule

// File: rtl/stereo_gain_ramp.sv
// stereo_gain_ramp: per-frame stereo gain with zipper-free ramp and one shared multiplier
module stereo_gain_ramp
  import audio_pkg::*;
(
  input logic clk,
  input logic rst,
  stereo_gain_ramp_if.slave bus
);
  state_t state;
  logic lrclk_q;
  logic frame;
  logic signed [BITSIZE-1:0] smp_l, smp_r, res_l, res_r, prod;
  logic [BITSIZE-1:0] out_l, out_r;
  logic valid;
  logic [GAIN_W-1:0] gain, eff;
  assign frame = bus.lrclk & ~lrclk_q;
  assign eff = bus.mute ? '0 : bus.target_gain;
  assign bus.out_left = out_l;
  assign bus.out_right = out_r;
  assign bus.out_valid = valid;
  assign bus.gain_now = gain;
  sat_scale u_scale (
    .sample(state == MUL_L ? smp_l : smp_r),
    .gain  (gain),
    .result(prod)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lrclk_q <= 1'b0;
      smp_l <= '0;
      smp_r <= '0;
      res_l <= '0;
      res_r <= '0;
      out_l <= '0;
      out_r <= '0;
      valid <= 1'b0;
      gain <= '0;
    end else begin
      lrclk_q <= bus.lrclk;
      valid <= 1'b0;
      case (state)
        IDLE: state <= frame ? CAP : IDLE;
        CAP: begin
          smp_l <= bus.in_left;
          smp_r <= bus.in_right;
          // step is clamped to the remaining distance so the ramp lands exactly on eff
          gain <= eff > gain ? (eff - gain <= GAIN_W'(STEP) ? eff : gain + GAIN_W'(STEP))
                             : (gain - eff <= GAIN_W'(STEP) ? eff : gain - GAIN_W'(STEP));
          state <= MUL_L;
        end
        MUL_L: begin
          res_l <= prod;
          state <= MUL_R;
        end
        MUL_R: begin
          res_r <= prod;
          state <= OUT;
        end
        OUT: begin
          out_l <= res_l;
          out_r <= res_r;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stereo_gain_ramp.sv
// tb_stereo_gain_ramp: frame-level reference model with per-cycle compare plus pinned literal cases
module tb_stereo_gain_ramp;
  import audio_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  stereo_gain_ramp_if bus();
  stereo_gain_ramp dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  int m_g, ph, eff;
  bit m_v, lr_prev;
  logic [23:0] m_l, m_r, cl, cr;

  function automatic logic [23:0] scale(logic [23:0] s, int g);
    longint p, r;
    p = longint'($signed(s)) * longint'(g);
    r = p >>> GAIN_FRAC;
    if (r > 64'sd8388607) r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
    return r[23:0];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_g = 0; m_l = '0; m_r = '0; m_v = 1'b0; ph = 0; lr_prev = 1'b0;
    end else begin
      m_v = 1'b0;
      if (ph == 0) begin
        if (bus.lrclk && !lr_prev) ph = 1;
      end else begin
        ph++;
        if (ph == 2) begin
          cl = bus.in_left;
          cr = bus.in_right;
          eff = bus.mute ? 0 : int'(bus.target_gain);
          m_g = (eff > m_g) ? ((m_g + STEP < eff) ? m_g + STEP : eff)
                            : ((m_g - STEP > eff) ? m_g - STEP : eff);
        end
        if (ph == 5) begin
          m_l = scale(cl, m_g);
          m_r = scale(cr, m_g);
          m_v = 1'b1;
          ph = 0;
        end
      end
      lr_prev = bus.lrclk;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      n_cmp++;
      if ({bus.out_valid, bus.out_left, bus.out_right, bus.gain_now} !== {m_v, m_l, m_r, GAIN_W'(m_g)}) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL cycle t=%0t: got v=%b l=%h r=%h g=%0d want v=%b l=%h r=%h g=%0d", $time,
                   bus.out_valid, bus.out_left, bus.out_right, bus.gain_now, m_v, m_l, m_r, m_g);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(output logic [23:0] l, output logic [23:0] r, output int vpos,
                           output int vcnt, input bit mid = 1'b0);
    vcnt = 0; vpos = -1; l = '0; r = '0;
    bus.lrclk = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        vcnt++; vpos = i; l = bus.out_left; r = bus.out_right;
      end
      if (i == 32) bus.lrclk = 1'b0;
      if (mid && i == 10) begin
        bus.target_gain = $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom);
        bus.mute = $urandom_range(0, 7) == 0;
      end
    end
  endtask

  logic [23:0] l, r;
  int vp, vc;

  initial begin
    bus.lrclk = 1'b0; bus.in_left = '0; bus.in_right = '0;
    bus.target_gain = 16'(UNITY_GAIN); bus.mute = 1'b0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    check("reset gain", 64'(bus.gain_now), 0);
    check("reset out_left", 64'(bus.out_left), 0);
    check("reset valid", 64'(bus.out_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    run_frame(l, r, vp, vc);
    check("ramp f1", 64'(bus.gain_now), 256);
    run_frame(l, r, vp, vc);
    check("ramp f2", 64'(bus.gain_now), 512);
    repeat (62) run_frame(l, r, vp, vc);
    check("ramp f64", 64'(bus.gain_now), 16384);
    run_frame(l, r, vp, vc);
    check("ramp f65", 64'(bus.gain_now), 16384);
    bus.in_left = 24'h100000; bus.in_right = 24'hF00000;
    run_frame(l, r, vp, vc);
    check("unity left", 64'(l), 64'h100000);
    check("unity right", 64'(r), 64'hF00000);
    check("unity latency", 64'(vp), 5);
    check("unity pulses", 64'(vc), 1);
    bus.target_gain = 16'd16500;
    run_frame(l, r, vp, vc);
    check("no overshoot", 64'(bus.gain_now), 16500);
    bus.target_gain = 16'd16384;
    run_frame(l, r, vp, vc);
    check("back to unity", 64'(bus.gain_now), 16384);
    bus.target_gain = 16'd8192; bus.in_left = 24'hFFFFFD; bus.in_right = 24'h000003;
    repeat (32) run_frame(l, r, vp, vc);
    check("half gain", 64'(bus.gain_now), 8192);
    check("floor neg", 64'(l), 64'hFFFFFE);
    check("floor pos", 64'(r), 64'h000001);
    bus.mute = 1'b1; bus.in_left = 24'h123456; bus.in_right = 24'hABCDEF;
    repeat (32) run_frame(l, r, vp, vc);
    check("mute gain", 64'(bus.gain_now), 0);
    check("mute left", 64'(l), 0);
    check("mute right", 64'(r), 0);
    bus.mute = 1'b0; bus.target_gain = 16'd32768;
    run_frame(l, r, vp, vc);
    check("unmute ramp", 64'(bus.gain_now), 256);
    repeat (126) run_frame(l, r, vp, vc);
    bus.in_left = 24'h500000; bus.in_right = 24'hA00000;
    run_frame(l, r, vp, vc);
    check("x2 gain", 64'(bus.gain_now), 32768);
    check("sat pos", 64'(l), 64'h7FFFFF);
    check("sat neg", 64'(r), 64'h800000);
    bus.lrclk = 1'b1;
    @(negedge clk); bus.lrclk = 1'b0;
    @(negedge clk); bus.lrclk = 1'b1;
    vc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) vc++;
    end
    check("glitch pulses", 64'(vc), 1);
    bus.lrclk = 1'b0;
    repeat (30) @(negedge clk);
    bus.lrclk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort gain", 64'(bus.gain_now), 0);
    check("abort left", 64'(bus.out_left), 0);
    check("abort valid", 64'(bus.out_valid), 0);
    bus.lrclk = 1'b0;
    vc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) vc++;
    end
    check("abort no pulse", 64'(vc), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.target_gain = 16'hFFFF;
    for (int f = 0; f < 40; f++) begin
      bus.in_left = 24'($urandom);
      bus.in_right = 24'($urandom);
      run_frame(l, r, vp, vc, 1'b1);
      check("rand pulses", 64'(vc), 1);
    end
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
